// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-digit dead time,
// per-frame value capture and optional leading-zero blanking.
module seg7_scan #(
   parameter int unsigned BLANK_CYCLES = 1000,
   parameter bit          LZ_SUPPRESS  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_tick,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_start
);

   typedef enum logic {BLANK, SHOW} state_t;

   localparam logic [15:0] RELOAD = 16'(BLANK_CYCLES);

   state_t      state, state_d;
   logic [15:0] cnt, cnt_d;
   logic [1:0]  idx, idx_d;
   logic [15:0] sval, sval_d;
   logic [3:0]  sdp, sdp_d;
   logic [3:0]  an_d;
   logic [6:0]  seg_d;
   logic        dp_d, fs_d;
   logic [15:0] upper;
   logic        lead, dpon;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= BLANK;
         cnt         <= RELOAD;
         idx         <= '0;
         sval        <= '0;
         sdp         <= '0;
         an          <= '1;
         seg         <= '1;
         dp          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         idx         <= idx_d;
         sval        <= sval_d;
         sdp         <= sdp_d;
         an          <= an_d;
         seg         <= seg_d;
         dp          <= dp_d;
         frame_start <= fs_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      sval_d  = sval;
      sdp_d   = sdp;
      fs_d    = 1'b0;
      case (state)
         BLANK: begin
            cnt_d = cnt - 16'd1;
            if (cnt == 16'd1) state_d = SHOW;
         end
         SHOW: begin
            if (scan_tick) begin
               idx_d   = idx + 2'd1;
               cnt_d   = RELOAD;
               state_d = BLANK;
               if (idx == 2'd3) begin
                  sval_d = value;
                  sdp_d  = dp_in;
                  fs_d   = 1'b1;
               end
            end
         end
         default: state_d = BLANK;
      endcase

      // Outputs are decoded from the post-edge state so the registers present it directly.
      upper = sval_d >> {idx_d, 2'b00};
      dpon  = sdp_d[idx_d];
      lead  = LZ_SUPPRESS && (idx_d != 2'd0) && (upper == '0);
      an_d  = '1;
      seg_d = '1;
      dp_d  = 1'b1;
      if (state_d == SHOW) begin
         seg_d = lead ? 7'h7F : hex7(upper[3:0]);
         dp_d  = ~dpon;
         if (!lead || dpon) an_d[idx_d] = 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized and directed bench for seg7_scan; two instances (leading-zero blanking on/off)
// are compared every cycle against an arithmetic display model.
module tb_seg7_scan;

   localparam int unsigned BC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_tick = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  an1, an0;
   logic [6:0]  seg1, seg0;
   logic        dp1, dp0, fs1, fs0;

   seg7_scan #(.BLANK_CYCLES(BC), .LZ_SUPPRESS(1'b1)) u_lz (
      .clk(clk), .rst_n(rst_n), .scan_tick(scan_tick), .value(value), .dp_in(dp_in),
      .an(an1), .seg(seg1), .dp(dp1), .frame_start(fs1));

   seg7_scan #(.BLANK_CYCLES(BC), .LZ_SUPPRESS(1'b0)) u_nolz (
      .clk(clk), .rst_n(rst_n), .scan_tick(scan_tick), .value(value), .dp_in(dp_in),
      .an(an0), .seg(seg0), .dp(dp0), .frame_start(fs0));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_fs = 0;
   int seen_fs = 0;
   string phase = "reset";

   // Display model: whether a digit is lit, which one, dead time left, captured frame.
   bit        m_show;
   int        m_left;
   int        m_idx;
   int        m_sval;
   logic [3:0] m_sdp;
   bit        m_fs;

   logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s [%s] t=%0t: got %h expected %h", tag, phase, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_show = 1'b0;
      m_left = BC;
      m_idx  = 0;
      m_sval = 0;
      m_sdp  = '0;
      m_fs   = 1'b0;
   endtask

   task automatic model_step(input logic tick, input logic [15:0] v, input logic [3:0] d);
      m_fs = 1'b0;
      if (!m_show) begin
         m_left--;
         if (m_left == 0) m_show = 1'b1;
      end else if (tick) begin
         if (m_idx == 3) begin
            m_sval = int'(v);
            m_sdp  = d;
            m_fs   = 1'b1;
            exp_fs++;
         end
         m_idx  = (m_idx + 1) % 4;
         m_show = 1'b0;
         m_left = BC;
      end
   endtask

   function automatic logic [12:0] expect_out(input bit lz);
      int sh;
      bit lead, dpon;
      logic [3:0] a;
      logic [6:0] s;
      if (!m_show) return {4'hF, 7'h7F, 1'b1, m_fs};
      sh   = m_sval / (16 ** m_idx);
      lead = lz && (m_idx > 0) && (sh == 0);
      dpon = m_sdp[m_idx];
      s    = lead ? 7'h7F : SEG[sh % 16];
      a    = (lead && !dpon) ? 4'hF : (4'hF ^ (4'b0001 << m_idx));
      return {a, s, !dpon, m_fs};
   endfunction

   task automatic cycle(input logic tick);
      scan_tick = tick;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step(tick, value, dp_in);
      @(negedge clk);
      check("lz_out", {an1, seg1, dp1, fs1}, expect_out(1'b1));
      check("nolz_out", {an0, seg0, dp0, fs0}, expect_out(1'b0));
      if (fs1) seen_fs++;
   endtask

   task automatic ticks(input int n);
      for (int t = 0; t < n; t++) begin
         for (int c = 0; c < 19; c++) cycle(1'b0);
         cycle(1'b1);
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_state", {an1, seg1, dp1, fs1}, {4'hF, 7'h7F, 1'b1, 1'b0});
      rst_n = 1'b1;

      phase = "hex_12AF";
      value = 16'h12AF;
      ticks(13);

      phase = "lz_dp";
      value = 16'h0005;
      dp_in = 4'b0100;
      ticks(9);

      phase = "no_tear";
      value = 16'h1111;
      dp_in = '0;
      ticks(5);
      for (int k = 0; k < 4 && m_idx != 1; k++) ticks(1);
      value = 16'h2222;
      for (int k = 0; k < 10 && !m_show; k++) cycle(1'b0);
      check("no_tear_d1", {25'd0, seg1}, {25'd0, 7'h79});
      ticks(9);

      phase = "held_tick";
      value = 16'h8888;
      ticks(4);
      for (int r = 0; r < 8; r++) begin
         int k0;
         for (int k = 0; k < 20 && !m_show; k++) cycle(r[0]);
         k0 = m_idx;
         repeat (3) cycle(1'b1);
         for (int k = 0; k < 10; k++) cycle(1'b0);
         check("one_advance", {28'd0, an1}, {28'd0, 4'hF ^ (4'b0001 << ((k0 + 1) % 4))});
      end

      phase = "async_reset";
      value = 16'h1234;
      for (int k = 0; k < 200 && !(m_show && m_idx == 2); k++) cycle(k % 20 == 19);
      check("on_digit2", {28'd0, an1}, {28'd0, 4'b1011});
      #2 rst_n = 1'b0;
      #1 check("async_blank", {an1, seg1, dp1, fs1}, {4'hF, 7'h7F, 1'b1, 1'b0});
      model_reset();
      cycle(1'b0);
      cycle(1'b0);
      rst_n = 1'b1;
      ticks(6);

      phase = "zero_nolz";
      value = 16'h0000;
      ticks(9);

      phase = "random";
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) value = 16'($urandom);
         if ($urandom_range(0, 99) == 0) value = 16'($urandom_range(0, 255));
         if ($urandom_range(0, 49) == 0) dp_in = 4'($urandom);
         cycle($urandom_range(0, 9) == 0);
      end

      phase = "final";
      check("frame_count", seen_fs, exp_fs);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
Time-multiplexed driver for the board's 4-digit common-anode 7-segment display. It consumes the 250 Hz scan strobe produced by the display clock divider and shows a 16-bit hex value, e.g. the processor's top-of-stack. One digit is lit per scan interval. A programmable dead-time is inserted between digits to suppress ghosting. The value is latched once per frame so a changing input never tears across digits.

Parameters:
BLANK_CYCLES, 1000, clk cycles all anodes are off between digits (10 us at 100 MHz); legal range 1..65535
LZ_SUPPRESS, 1, 1 = blank leading zero digits 3..1; digit 0 is always shown

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
scan_tick  input  1  one-clk-wide enable pulse at scan rate, synchronous to clk (250 Hz)
value  input  16  hex value to display; nibble k shown on digit k, digit 0 rightmost
dp_in  input  4  decimal point request per digit, 1 = lit
an  output  4  anode enables, active-low; an[k] drives digit k
seg  output  7  cathodes, active-low, {g,f,e,d,c,b,a}
dp  output  1  decimal point cathode, active-low
frame_start  output  1  one-clk pulse when value/dp_in are captured into the shadow registers

Behaviour:
- Reset is asynchronous and applies immediately, including mid-frame: an=4'hF, seg=7'h7F, dp=1, frame_start=0, digit index=0, shadow value=0, shadow dp=0, state=BLANK, blank counter=BLANK_CYCLES.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM states:
  - BLANK: an=4'hF, seg=7'h7F, dp=1. The counter decrements each clk. On the cycle the counter would reach 0, the next state is SHOW. BLANK therefore lasts exactly BLANK_CYCLES clks.
  - SHOW: an[idx]=0 and other anodes 1; seg/dp driven from shadow nibble idx. On scan_tick: idx <= idx+1 mod 4, counter <= BLANK_CYCLES, next state BLANK.
- scan_tick is ignored while in BLANK. It is not queued. scan_tick held high longer than one clk advances at most one digit per SHOW entry.
- Latency: scan_tick sampled at edge T in SHOW gives an=4'hF from T+1. The next digit's anode goes low at T+1+BLANK_CYCLES.
- Frame capture: when idx wraps 3->0 (the same edge as the transition to BLANK), shadow value <= value and shadow dp <= dp_in. frame_start=1 for exactly that one clk.
- After reset, the first capture occurs only at the first wrap. Until then, digits 3..0 display the shadow reset value (0, with leading-zero rules applied).
- Hex decode (seg, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Leading-zero suppression (LZ_SUPPRESS=1): digit k (k=3..1) is blank if shadow nibbles k..3 are all 0. A blank digit drives seg=7'h7F.
  - If the blank digit's shadow dp is 1: anode is still driven low and dp=0.
  - Otherwise: anode stays high for that SHOW period.
- With LZ_SUPPRESS=0, all four digits are always decoded.
- dp = ~shadow_dp[idx] during SHOW.
- frame_start never asserts outside a 3->0 wrap.

Test Plan:
- Reset then release, BLANK_CYCLES=4, value=16'h12AF, scan_tick every 20 clks -> an sequence 1110,1101,1011,0111 with 4-clk an=1111 gaps; first frame shows 0 on digit 0 only; after first wrap frame_start pulses once and digits show F,A,2,1 (seg 0E,08,24,79).
- value=16'h0005, LZ_SUPPRESS=1, dp_in=4'b0100 -> digit 0 seg=12; digit 1 anode stays high; digit 2 an=1011 with seg=7F and dp=0; digit 3 anode stays high.
- value changes 16'h1111->16'h2222 while idx=1 -> digits 1..3 of the current frame still show 1 (seg=79); 2 (seg=24) appears only after the next frame_start.
- scan_tick asserted during BLANK and held high for 3 clks in SHOW -> exactly one digit advance per SHOW entry; ticks in BLANK have no effect.
- rst_n asserted asynchronously mid-SHOW on digit 2 -> an=F, seg=7F, dp=1 before the next clk edge; after release idx=0, BLANK_CYCLES gap, shadow=0.
- LZ_SUPPRESS=0, value=16'h0000 -> all four digits show seg=40 in order 0..3.
